// File: rtl/alu_op_sequencer.sv
// Stepwise operand-entry front end for the board ALU: debounced step/clear buttons
// load A, B and the function code, then one EXEC cycle latches result and flags for display.
module alu_op_sequencer #(
  parameter int WIDTH           = 5,
  parameter int FUNC_W          = 3,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        btn,
  input  logic [15:0]       sw,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [FUNC_W-1:0] alu_func,
  input  logic [WIDTH-1:0]  alu_out,
  input  logic              alu_zero,
  input  logic              alu_ovf,
  input  logic              alu_cout,
  output logic [3:0]        seg1,
  output logic [3:0]        seg2,
  output logic [15:0]       ledr
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    LOAD_F = 3'd2,
    EXEC   = 3'd3,
    SHOW   = 3'd4
  } state_t;

  // Index 0 is the step button, index 1 the clear button.
  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       stable_q, stable_d;
  logic [1:0]       stable_dly_q, stable_dly_d;
  logic [1:0]       pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [FUNC_W-1:0] func_q, func_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              zero_q, zero_d;
  logic              ovf_q, ovf_d;
  logic              cout_q, cout_d;
  logic              valid_q, valid_d;

  logic step_pls;
  logic clr_pls;
  logic [4:0] state_oh;
  logic unused_inputs;

  assign unused_inputs = ^{btn[4:2], sw[15:10+FUNC_W], sw[9:WIDTH]};

  // Synchronize, then accept a new level only after it has persisted long enough.
  always_comb begin
    sync1_d      = btn[1:0];
    sync2_d      = sync1_q;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    pulse_d = stable_q & ~stable_dly_q;
  end

  assign step_pls = pulse_q[0];
  assign clr_pls  = pulse_q[1];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    func_d  = func_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    cout_d  = cout_q;
    valid_d = valid_q;
    if (clr_pls) begin
      state_d = LOAD_A;
      a_d     = '0;
      b_d     = '0;
      func_d  = '0;
      res_d   = '0;
      zero_d  = 1'b0;
      ovf_d   = 1'b0;
      cout_d  = 1'b0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        LOAD_A: if (step_pls) begin
          a_d     = sw[WIDTH-1:0];
          state_d = LOAD_B;
        end
        LOAD_B: if (step_pls) begin
          b_d     = sw[WIDTH-1:0];
          state_d = LOAD_F;
        end
        LOAD_F: if (step_pls) begin
          func_d  = sw[10 +: FUNC_W];
          state_d = EXEC;
        end
        // The ALU has seen the registered operands for this whole cycle.
        EXEC: begin
          res_d   = alu_out;
          zero_d  = alu_zero;
          ovf_d   = alu_ovf;
          cout_d  = alu_cout;
          valid_d = 1'b1;
          state_d = SHOW;
        end
        SHOW: if (step_pls) begin
          valid_d = 1'b0;
          state_d = LOAD_A;
        end
        default: state_d = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      pulse_q      <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
      state_q      <= LOAD_A;
      a_q          <= '0;
      b_q          <= '0;
      func_q       <= '0;
      res_q        <= '0;
      zero_q       <= 1'b0;
      ovf_q        <= 1'b0;
      cout_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      pulse_q      <= pulse_d;
      for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      func_q       <= func_d;
      res_q        <= res_d;
      zero_q       <= zero_d;
      ovf_q        <= ovf_d;
      cout_q       <= cout_d;
      valid_q      <= valid_d;
    end
  end

  always_comb begin
    state_oh = 5'b00000;
    case (state_q)
      LOAD_A:  state_oh = 5'b00001;
      LOAD_B:  state_oh = 5'b00010;
      LOAD_F:  state_oh = 5'b00100;
      EXEC:    state_oh = 5'b01000;
      SHOW:    state_oh = 5'b10000;
      default: state_oh = 5'b00000;
    endcase
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_func = func_q;
  assign seg1     = res_q[3:0];
  assign seg2     = {3'b000, res_q[4]};
  assign ledr     = {valid_q, 2'b00, state_oh, cout_q, ovf_q, zero_q, res_q[4:0]};

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Sequential operand-entry front end for the 5-bit ALU on the board top level.
- Debounces the board push-buttons and captures operand A, operand B and the function code from the switches in three button-driven steps.
- Drives the captured values into the ALU, latches the ALU's result and flags, and presents them on the LEDs and 4-bit segment outputs.
- Replaces direct switch-to-ALU wiring with registered, stepwise entry.

Parameters:
WIDTH, 5, operand/result width
FUNC_W, 3, function-code width
DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required before a button level is accepted (minimum 2)

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  synchronous active-low reset
btn  input  5  raw push-buttons; btn[0]=step, btn[1]=clear, btn[4:2] unused
sw  input  16  switches; sw[4:0] operand value, sw[12:10] function code, others unused
alu_a  output  WIDTH  registered operand A to ALU
alu_b  output  WIDTH  registered operand B to ALU
alu_func  output  FUNC_W  registered function code to ALU
alu_out  input  WIDTH  ALU result (combinational from alu_a/b/func)
alu_zero  input  1  ALU zero flag
alu_ovf  input  1  ALU overflow flag
alu_cout  input  1  ALU carry-out flag
seg1  output  4  latched result[3:0]
seg2  output  4  {3'b000, latched result[4]}
ledr  output  16  status/result LEDs

Behaviour:
- Reset: rst sampled low on a rising edge clears all registers.
  - alu_a/alu_b/alu_func=0, result/flags=0, valid=0.
  - seg1=0, seg2=0; ledr=16'h0100 (state LOAD_A).
  - Debounce stable levels, counters and synchronizers =0.
  - Reset mid-operation, including during EXEC, discards everything; no partial result is kept.
- Debounce, per used button (btn[0], btn[1]):
  - 2-flop synchronizer, then a counter.
  - The counter increments while the synchronized level differs from the stable level, and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the stable level toggles and the counter clears.
  - A press pulse is high for exactly 1 cycle, the cycle after the stable level rises 0->1.
  - Latency: a raw level held from edge k produces the pulse in cycle k+DEBOUNCE_CYCLES+2.
  - Glitches shorter than DEBOUNCE_CYCLES synchronized cycles produce no pulse.
  - Holding a button produces exactly one pulse. Release produces none.
- FSM states: LOAD_A, LOAD_B, LOAD_F, EXEC, SHOW.
  - LOAD_A + step pulse: alu_a<=sw[4:0]; ->LOAD_B.
  - LOAD_B + step: alu_b<=sw[4:0]; ->LOAD_F.
  - LOAD_F + step: alu_func<=sw[12:10]; ->EXEC.
  - EXEC: unconditional single cycle; step pulses are ignored.
    - At the end of EXEC, latch result<=alu_out, zero/ovf/cout<=ALU flags, valid<=1; ->SHOW.
    - The ALU therefore sees stable registered inputs for one full cycle before sampling.
  - SHOW + step: valid<=0; ->LOAD_A. Result and flags are kept for display until the next EXEC overwrites them.
  - Clear pulse in any state, EXEC included: alu_a/alu_b/alu_func<=0, valid<=0, result/flags<=0; ->LOAD_A.
  - Clear and step pulses in the same cycle: clear wins.
- Capture timing: registers update on the edge ending the pulse cycle. Switches changing after that edge do not affect captured values.
- ledr mapping:
  - [4:0] latched result; [5] zero; [6] overflow; [7] carry-out.
  - [12:8] one-hot state (bit8 LOAD_A, 9 LOAD_B, 10 LOAD_F, 11 EXEC, 12 SHOW).
  - [14:13]=0; [15] valid.
- Every output is registered or a direct function of registers; none depends combinationally on btn/sw.
- Width rules:
  - Operands are captured unmodified.
  - sw bits outside [4:0] and [12:10] are ignored.
  - No arithmetic is performed in this block.

Test Plan:
- DEBOUNCE_CYCLES=4, ideal adder stub ALU (func 000). Steps: sw[4:0]=7, step; =9, step; sw[12:10]=000, step -> alu_a=7, alu_b=9. One cycle later: ledr[4:0]=10000, seg1=0, seg2=1, ledr[15]=1, ledr[12]=1.
- btn[0] high for 2 cycles, then low -> no pulse, state stays LOAD_A. Held high 40 cycles -> exactly one transition to LOAD_B, at cycle k+6.
- In LOAD_F after A=3, B=4, assert clear -> alu_a=alu_b=alu_func=0, ledr=16'h0100. Then a full entry A=1, B=1 -> result 2.
- Clear and step pulses in the same cycle while in LOAD_B -> state LOAD_A, alu_b unchanged at 0.
- rst low for 1 cycle while in EXEC -> next cycle all outputs at reset values, ledr[15]=0, result not latched.
- Stub ALU returning out=0 with zero=1, ovf=1, cout=1 -> ledr[7:5]=111, seg1=0, seg2=0. Step from SHOW -> ledr[15]=0, flags still displayed.
